// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state type, the x0 register id and wait-counter sizing.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int HZ_MAX_WAIT_DEF = 16;

    function automatic int hz_wait_w(input int max_wait);
        return $clog2(max_wait) + 1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// hz_sat_counter: enabled up-counter that sticks at all-ones.
// Ports: clk, rst_n (async low), i_en (count), o_cnt (W-bit value).
module hz_sat_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / branch / dmem-wait hazard control with a
// wait-state watchdog. Inputs: ID sources, EX dest/load flag, branch_taken,
// dmem_req/ready. Outputs: ctrlf, pc_write, ifid_write, ifid_flush,
// pipe_hold, sticky mem_timeout. Macro HAZARD_PERF_CNT_EN adds
// load_stall_cnt, flush_cnt and memwait_cnt (CNT_W bits, saturating).
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = HZ_MAX_WAIT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             ctrlf,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pipe_hold,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
`endif
    output logic             mem_timeout
);

    localparam int WAIT_W = hz_wait_w(MAX_WAIT);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic w_mem_stall;
    logic w_load_use;
    logic w_live;
    logic w_sel_mem;
    logic w_sel_br;
    logic w_sel_lu;

    assign w_mem_stall = dmem_req & ~dmem_ready;

    assign w_load_use = ex_memread & (ex_rd != REG_X0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

    // One-hot pick of the winning hazard; none fire once in ERROR.
    assign w_live    = (r_state != ERROR);
    assign w_sel_mem = w_live & w_mem_stall;
    assign w_sel_br  = w_live & ~w_mem_stall & branch_taken;
    assign w_sel_lu  = w_live & ~w_mem_stall & ~branch_taken & w_load_use;

    always_comb begin
        ctrlf      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (!rst_n) begin
            ctrlf      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else if (!w_live) begin
            ctrlf      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (w_sel_mem) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (w_sel_br) begin
            ctrlf      = 1'b1;
            ifid_flush = 1'b1;
        end else if (w_sel_lu) begin
            ctrlf      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_timeout;
        unique case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else begin
                    w_wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                // Dropping dmem_req also lands here as a completion.
                if (!w_mem_stall) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_state_nxt   = ERROR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                w_state_nxt = ERROR;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign mem_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    hz_sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_sel_lu),
        .o_cnt (load_stall_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_sel_br),
        .o_cnt (flush_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_mw_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_sel_mem),
        .o_cnt (memwait_cnt)
    );
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MAX_WAIT=4, CNT_W=4).
// Counter ports are exercised when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_ctrl;

    localparam int MW  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_memread = 0;
    logic       branch_taken = 0, dmem_req = 0, dmem_ready = 0;
    logic       ctrlf, pc_write, ifid_write, ifid_flush, pipe_hold;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] load_stall_cnt, flush_cnt, memwait_cnt;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .ctrlf        (ctrlf),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .pipe_hold    (pipe_hold),
`ifdef HAZARD_PERF_CNT_EN
        .load_stall_cnt (load_stall_cnt),
        .flush_cnt      (flush_cnt),
        .memwait_cnt    (memwait_cnt),
`endif
        .mem_timeout  (mem_timeout)
    );

    // {ctrlf, pc_write, ifid_write, ifid_flush, pipe_hold, mem_timeout}
    typedef logic [5:0] exp_t;
    localparam exp_t E_RST  = 6'b100100;
    localparam exp_t E_ERR  = 6'b100011;
    localparam exp_t E_HOLD = 6'b000010;
    localparam exp_t E_BR   = 6'b111100;
    localparam exp_t E_LU   = 6'b100000;
    localparam exp_t E_NONE = 6'b011000;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: count of consecutive stalled edges and a dead flag.
    int   m_run = 0;
    bit   m_dead = 0;
    int   m_lu = 0, m_br = 0, m_mw = 0;

    exp_t mon_e;
    exp_t mon_a;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = {ctrlf, pc_write, ifid_write, ifid_flush, pipe_hold,
                     mem_timeout};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%b exp=%b", $time,
                         mon_a, mon_e);
            end
        end
    end

    function automatic int satv(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic cnt_check();
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (int'(load_stall_cnt) != satv(m_lu) ||
            int'(flush_cnt) != satv(m_br) ||
            int'(memwait_cnt) != satv(m_mw)) begin
            failures++;
            $display("FAIL counters t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     $time, load_stall_cnt, flush_cnt, memwait_cnt,
                     satv(m_lu), satv(m_br), satv(m_mw));
        end
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q.push_back(E_RST);
        m_run  = 0;
        m_dead = 0;
        m_lu   = 0;
        m_br   = 0;
        m_mw   = 0;
    endtask

    task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit u1, input bit u2,
                         input bit mr, input bit br, input bit req,
                         input bit rdy);
        bit   stall;
        bit   lu;
        exp_t e;
        @(posedge clk);
        #1;
        cnt_check();
        rst_n        = 1'b1;
        id_rs1       = rs1;
        id_rs2       = rs2;
        ex_rd        = rd;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        ex_memread   = mr;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        stall = req && !rdy;
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (m_dead)     e = E_ERR;
        else if (stall) e = E_HOLD;
        else if (br)    e = E_BR;
        else if (lu)    e = E_LU;
        else            e = E_NONE;
        q.push_back(e);
        if (!m_dead) begin
            if (stall) begin
                m_run++;
                m_mw++;
                if (m_run == MW) m_dead = 1;
            end else begin
                m_run = 0;
                if (br)      m_br++;
                else if (lu) m_lu++;
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stall_cyc(input bit br);
        cycle(0, 0, 0, 0, 0, 0, br, 1, 0);
    endtask

    initial begin
        do_reset();
        idle();
        idle();
        // load-use on rs2, then cleared; rd=x0 and unused rs2 never stall
        cycle(0, 5, 5, 0, 1, 1, 0, 0, 0);
        idle();
        cycle(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cycle(0, 5, 5, 0, 0, 1, 0, 0, 0);
        cycle(5, 0, 5, 1, 0, 1, 0, 0, 0);
        // branch beats load-use
        cycle(0, 5, 5, 0, 1, 1, 1, 0, 0);
        // three stalled cycles with a pending branch, then release
        stall_cyc(1);
        stall_cyc(1);
        stall_cyc(1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle();
        // dropping dmem_req mid-wait is a completion
        stall_cyc(0);
        stall_cyc(0);
        idle();
        // four stalled cycles trip the watchdog
        for (int i = 0; i < MW; i++) stall_cyc(0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 5, 5, 0, 1, 1, 1, 0, 0);
        idle();
        do_reset();
        idle();
        // reset in the middle of a stall
        stall_cyc(0);
        stall_cyc(0);
        do_reset();
        idle();
        // long load-use run saturates the counter; then a 3-cycle wait
        for (int i = 0; i < 17; i++) cycle(3, 0, 3, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) stall_cyc(0);
        idle();
        idle();
        // randomized traffic with occasional stall bursts and resets
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else if ($urandom_range(0, 99) < 4) begin
                int len;
                len = $urandom_range(1, MW + 1);
                for (int k = 0; k < len; k++) stall_cyc($urandom_range(0, 1) == 1);
            end else begin
                cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 2,
                      $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5);
            end
        end
        @(posedge clk);
        #1;
        cnt_check();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard/stall controller for the 5-stage RV32 pipeline, directly upstream of the control bubble mux.
- Drives the mux's ctrlf bubble select, PC/IF-ID write enables, the IF-ID flush and a global pipeline hold.
- Detects three conditions: load-use hazards, taken-branch squashes and data-memory wait states.
- A wait-state watchdog FSM converts an unresponsive data memory into a sticky error.

Parameters:
- MAX_WAIT, 16, consecutive not-ready cycles tolerated before timeout (legal range 2..255).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination register
- ex_memread  in  1  EX-stage instruction is a load
- branch_taken  in  1  EX-stage branch/jump resolved taken
- dmem_req  in  1  MEM stage issuing a load/store this cycle
- dmem_ready  in  1  data memory completes access this cycle
- ctrlf  out  1  1 = bubble-mux zeroes ID/EX control
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n low, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0.
- Outputs while rst_n is low: ctrlf=1, pc_write=0, ifid_write=0, ifid_flush=1, pipe_hold=0.
- States:
  - RUN: normal operation.
  - MEM_WAIT: data memory has stalled.
  - ERROR: terminal until reset.
- mem_stall = dmem_req & ~dmem_ready.
- load_use = ex_memread & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- All hazard outputs are combinational (Mealy) from the current state and inputs; zero-cycle latency. Only state, wait_cnt and mem_timeout are registered.
- Priority, highest first, in RUN/MEM_WAIT:
  1. mem_stall: pipe_hold=1, pc_write=0, ifid_write=0, ctrlf=0, ifid_flush=0. The whole pipeline freezes and no bubble is inserted; any coincident branch_taken or load_use is re-evaluated once the stall releases.
  2. branch_taken: ctrlf=1, ifid_flush=1, pc_write=1, ifid_write=1. Squashes the two younger instructions; the PC loads the target.
  3. load_use: ctrlf=1, pc_write=0, ifid_write=0. One bubble; this does not repeat next cycle because the load has moved to MEM.
  4. None of the above: ctrlf=0, pc_write=1, ifid_write=1, ifid_flush=0, pipe_hold=0.
- Transitions:
  - RUN to MEM_WAIT on mem_stall; wait_cnt<=1.
  - MEM_WAIT stays on mem_stall; wait_cnt<=wait_cnt+1.
  - MEM_WAIT to RUN when ~mem_stall; wait_cnt<=0.
  - MEM_WAIT to ERROR when mem_stall & (wait_cnt == MAX_WAIT-1). The timeout fires on the MAX_WAIT-th consecutive stalled cycle; mem_timeout<=1.
  - Dropping dmem_req during MEM_WAIT counts as completion, so the FSM returns to RUN.
  - RUN with ~mem_stall keeps wait_cnt at 0.
- ERROR: pipe_hold=1, pc_write=0, ifid_write=0, ctrlf=1, ifid_flush=0; all inputs are ignored. Only rst_n exits.
- wait_cnt width: $clog2(MAX_WAIT)+1. It never wraps because ERROR is entered first.
- Reset asserted mid-stall: immediate return to RUN with outputs at their reset values; no partial state survives.
- ex_rd = 0 never raises a load-use hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds output ports load_stall_cnt, flush_cnt and memwait_cnt, each CNT_W bits.
  - Each increments by 1 on every clock edge where its priority case (load_use, branch_taken, mem_stall respectively) is the one selected.
  - Counters saturate at all-ones and reset to 0.
  - They do not increment while in ERROR.
- When undefined, these ports and registers are absent and all other behaviour is identical.

Decomposition:
- Shared package: hz_state_t enum (RUN, MEM_WAIT, ERROR), the x0 register constant, and the default for the wait-counter width.
- One natural sub-module, hz_sat_counter: parameterised saturating counter with enable, instantiated three times under the macro.
- Load-use comparison stays inline.

Test Plan:
- Reset with rst_n=0 mid-cycle: ctrlf=1, ifid_flush=1, pc_write=0 immediately; after release with no hazards, ctrlf=0, pc_write=1, ifid_write=1.
- ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1: exactly one cycle of ctrlf=1, pc_write=0, ifid_write=0. With ex_rd=0, or with id_uses_rs2=0, no stall.
- branch_taken=1 together with load_use=1: ctrlf=1, ifid_flush=1, pc_write=1 (the branch wins).
- MAX_WAIT=4, dmem_req=1, dmem_ready low for 3 cycles then high: pipe_hold=1 for 3 cycles, then RUN; mem_timeout stays 0. A coincident branch_taken is deferred until the stall releases.
- MAX_WAIT=4, dmem_ready low for 4 cycles: mem_timeout=1 after the 4th edge and stays 1 with dmem_ready later high; pipe_hold stays 1 until rst_n pulses low.
- HAZARD_PERF_CNT_EN with CNT_W=4: 17 load-use cycles give load_stall_cnt=15 (saturated); one 3-cycle memory stall gives memwait_cnt=3.
